// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the clock step controller.
// Command opcodes and per-channel FSM states.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_HALT = 2'b00,
      OP_RUN  = 2'b01,
      OP_STEP = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_e;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clock_step_control_if.sv
// Command channel from the debug monitor to the clock controller.
// Valid/ready request plus a one-cycle error pulse back.
interface clock_step_control_if
   import clock_ctrl_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16
);
   localparam int CH_W = ch_w(NUM_CH);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [CH_W-1:0]  cmd_ch;
   op_e              cmd_op;
   logic [CNT_W-1:0] cmd_count;
   logic             cmd_err;

   modport master (
      output cmd_valid, cmd_ch, cmd_op, cmd_count,
      input  cmd_ready, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_ch, cmd_op, cmd_count,
      output cmd_ready, cmd_err
   );

endinterface

// File: rtl/clock_gate_cell.sv
// Glitch-free clock gate: enable captured while clock is low,
// so a change of en can never truncate a high phase.
module clock_gate_cell (
   input  logic clk_in,
   input  logic en,
   output logic clk_out
);

   logic en_l;

   always_latch begin
      if (!clk_in) en_l <= en;
   end

   assign clk_out = clk_in & en_l;

endmodule

// File: rtl/clock_step_control.sv
// Multi-channel clock controller: per channel run, halt or
// single-step N cycles, with registered enable and gated clock.
module clock_step_control
   import clock_ctrl_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int CNT_W     = 16,
   parameter bit RESET_RUN = 1'b1
) (
   input  logic              clk_in,
   input  logic              reset,
   clock_step_control_if.slave cmd,
   output logic [NUM_CH-1:0] clk_en,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] ch_busy,
   output logic [NUM_CH-1:0] step_done
);

   localparam int CH_W = ch_w(NUM_CH);
   localparam int PAD  = 1 << CH_W;

   logic [PAD-1:0] busy_pad;
   logic           ch_ok;
   logic           acc;
   logic           err_q, err_d;

   // Out-of-range channels read as idle so they are never stalled
   always_comb begin
      busy_pad = '0;
      busy_pad[NUM_CH-1:0] = ch_busy;
   end

   assign ch_ok = 32'(cmd.cmd_ch) < NUM_CH;
   assign cmd.cmd_ready = !reset &&
      !(cmd.cmd_op == OP_STEP && busy_pad[cmd.cmd_ch]);
   assign acc = cmd.cmd_valid && cmd.cmd_ready;

   assign err_d = acc && (cmd.cmd_op == OP_RSVD || !ch_ok);
   assign cmd.cmd_err = err_q;

   always_ff @(posedge clk_in) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_e           st_q, st_d;
      logic [CNT_W-1:0] rem_q, rem_d;
      logic             en_q, en_d;
      logic             done_q, done_d;
      logic             hit;

      assign hit = acc && ch_ok && cmd.cmd_op != OP_RSVD &&
                   cmd.cmd_ch == CH_W'(i);

      always_comb begin
         st_d   = st_q;
         rem_d  = rem_q;
         done_d = 1'b0;
         if (st_q == ST_STEP && rem_q != '0) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
               st_d   = ST_HALT;
               done_d = 1'b1;
            end
         end
         // An accepted command overrides any step completing now
         if (hit) begin
            unique case (cmd.cmd_op)
               OP_HALT: begin
                  st_d = ST_HALT; rem_d = '0; done_d = 1'b0;
               end
               OP_RUN: begin
                  st_d = ST_RUN; rem_d = '0; done_d = 1'b0;
               end
               OP_STEP: begin
                  rem_d = cmd.cmd_count;
                  if (cmd.cmd_count == '0) begin
                     st_d = ST_HALT; done_d = 1'b1;
                  end else begin
                     st_d = ST_STEP; done_d = 1'b0;
                  end
               end
               default: ;
            endcase
         end
         en_d = (st_d == ST_RUN) || (st_d == ST_STEP);
      end

      always_ff @(posedge clk_in) begin
         if (reset) begin
            st_q   <= RESET_RUN ? ST_RUN : ST_HALT;
            rem_q  <= '0;
            en_q   <= RESET_RUN;
            done_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            rem_q  <= rem_d;
            en_q   <= en_d;
            done_q <= done_d;
         end
      end

      assign clk_en[i]    = en_q;
      assign ch_busy[i]   = st_q == ST_STEP;
      assign step_done[i] = done_q;

      clock_gate_cell u_gate (
         .clk_in  (clk_in),
         .en      (en_q),
         .clk_out (clk_out[i])
      );
   end

endmodule

// File: tb/tb_clock_step_control.sv
// Self-checking bench for clock_step_control: cycle-exact
// expectations queued per stimulus and popped after each edge.
module tb_clock_step_control;
   import clock_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic [1:0] clk_en, clk_out, ch_busy, step_done;
   logic [2:0] en3, out3, busy3, done3;

   always #5 clk = ~clk;

   clock_step_control_if #(.NUM_CH(2), .CNT_W(16)) cmd_if ();
   clock_step_control_if #(.NUM_CH(3), .CNT_W(16)) if3 ();

   clock_step_control #(.NUM_CH(2), .CNT_W(16), .RESET_RUN(1'b1)) u_dut (
      .clk_in    (clk),
      .reset     (reset),
      .cmd       (cmd_if),
      .clk_en    (clk_en),
      .clk_out   (clk_out),
      .ch_busy   (ch_busy),
      .step_done (step_done)
   );

   clock_step_control #(.NUM_CH(3), .CNT_W(16), .RESET_RUN(1'b1)) u_dut3 (
      .clk_in    (clk),
      .reset     (reset),
      .cmd       (if3),
      .clk_en    (en3),
      .clk_out   (out3),
      .ch_busy   (busy3),
      .step_done (done3)
   );

   typedef struct packed {
      logic [1:0] en;
      logic [1:0] busy;
      logic [1:0] done;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;
   int ed0 = 0, ed1 = 0;
   int b0, b1;

   always @(posedge clk_out[0]) ed0++;
   always @(posedge clk_out[1]) ed1++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [1:0] en, input logic [1:0] busy,
                       input logic [1:0] done, input logic err);
      exp_t e;
      e.en = en; e.busy = busy; e.done = done; e.err = err;
      sb.push_back(e);
   endtask

   task automatic tick;
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("clk_en", 32'(clk_en), 32'(e.en));
         chk("ch_busy", 32'(ch_busy), 32'(e.busy));
         chk("step_done", 32'(step_done), 32'(e.done));
         chk("cmd_err", 32'(cmd_if.cmd_err), 32'(e.err));
      end
   endtask

   task automatic drive(input logic v, input logic ch, input op_e op,
                        input logic [15:0] cnt);
      cmd_if.cmd_valid = v;
      cmd_if.cmd_ch    = ch;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_count = cnt;
   endtask

   task automatic idle;
      drive(1'b0, 1'b0, OP_HALT, 16'd0);
   endtask

   task automatic drive3(input logic v, input logic [1:0] ch,
                         input op_e op);
      if3.cmd_valid = v;
      if3.cmd_ch    = ch;
      if3.cmd_op    = op;
      if3.cmd_count = 16'd0;
   endtask

   task automatic rdy(input string tag, input logic exp);
      #1;
      chk(tag, 32'(cmd_if.cmd_ready), 32'(exp));
   endtask

   initial begin
      reset = 1'b1;
      idle();
      drive3(1'b0, 2'd0, OP_HALT);
      @(posedge clk);
      rdy("rdy_in_reset", 1'b0);
      push(2'b11, 2'b00, 2'b00, 1'b0);
      tick();

      reset = 1'b0;
      b0 = ed0; b1 = ed1;
      push(2'b11, 2'b00, 2'b00, 1'b0);
      tick();
      push(2'b11, 2'b00, 2'b00, 1'b0);
      tick();
      chk("run_edges0", 32'(ed0 - b0), 32'd2);
      chk("run_edges1", 32'(ed1 - b1), 32'd2);

      drive(1'b1, 1'b0, OP_HALT, 16'd0);
      rdy("rdy_halt", 1'b1);
      push(2'b10, 2'b00, 2'b00, 1'b0);
      tick();

      drive(1'b1, 1'b0, OP_STEP, 16'd3);
      rdy("rdy_step3", 1'b1);
      b0 = ed0;
      push(2'b11, 2'b01, 2'b00, 1'b0);
      tick();
      idle();
      push(2'b11, 2'b01, 2'b00, 1'b0);
      tick();
      push(2'b11, 2'b01, 2'b00, 1'b0);
      tick();
      push(2'b10, 2'b00, 2'b01, 1'b0);
      tick();
      push(2'b10, 2'b00, 2'b00, 1'b0);
      tick();
      chk("step3_edges", 32'(ed0 - b0), 32'd3);

      drive(1'b1, 1'b1, OP_STEP, 16'd0);
      push(2'b00, 2'b00, 2'b10, 1'b0);
      tick();
      idle();
      push(2'b00, 2'b00, 2'b00, 1'b0);
      tick();

      drive(1'b1, 1'b0, OP_STEP, 16'd10);
      push(2'b01, 2'b01, 2'b00, 1'b0);
      tick();
      idle();
      push(2'b01, 2'b01, 2'b00, 1'b0);
      tick();
      for (int j = 0; j < 3; j++) begin
         drive(1'b1, 1'b0, OP_STEP, 16'd5);
         rdy("rdy_stall", 1'b0);
         push(2'b01, 2'b01, 2'b00, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, OP_HALT, 16'd0);
      rdy("rdy_halt_busy", 1'b1);
      push(2'b00, 2'b00, 2'b00, 1'b0);
      tick();
      idle();
      push(2'b00, 2'b00, 2'b00, 1'b0);
      tick();
      push(2'b00, 2'b00, 2'b00, 1'b0);
      tick();

      drive(1'b1, 1'b1, OP_RSVD, 16'd0);
      drive3(1'b1, 2'd3, OP_RUN);
      rdy("rdy_rsvd", 1'b1);
      chk("rdy_range3", 32'(if3.cmd_ready), 32'd1);
      push(2'b00, 2'b00, 2'b00, 1'b1);
      tick();
      chk("err_range3", 32'(if3.cmd_err), 32'd1);
      chk("en_range3", 32'(en3), 32'h7);
      idle();
      drive3(1'b0, 2'd0, OP_HALT);
      push(2'b00, 2'b00, 2'b00, 1'b0);
      tick();
      chk("err_range3_clr", 32'(if3.cmd_err), 32'd0);

      drive(1'b1, 1'b0, OP_STEP, 16'd10);
      push(2'b01, 2'b01, 2'b00, 1'b0);
      tick();
      idle();
      for (int j = 0; j < 3; j++) begin
         push(2'b01, 2'b01, 2'b00, 1'b0);
         tick();
      end
      reset = 1'b1;
      drive(1'b1, 1'b1, OP_HALT, 16'd0);
      rdy("rdy_reset_mid", 1'b0);
      push(2'b11, 2'b00, 2'b00, 1'b0);
      tick();
      reset = 1'b0;
      idle();
      push(2'b11, 2'b00, 2'b00, 1'b0);
      tick();
      push(2'b11, 2'b00, 2'b00, 1'b0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
